level_game_control: RTL and testbench

LEVEL_GAME_CONTROL -- requirements
Module: level_game_control

---
 rtl/game_pkg.sv | 23 ++
 rtl/rise_detect.sv | 19 +
 rtl/level_game_control.sv | 171 +++++++++++++++++
 tb/tb_level_game_control.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types for the level/game sequencer: state encoding and the
// message codes shown by the overlay.
package game_pkg;

    typedef enum logic [3:0] {
        PRE_GAME   = 4'd0,
        PLAY       = 4'd1,
        LOST_LIFE  = 4'd2,
        RESPAWN    = 4'd3,
        GAIN_LIFE  = 4'd4,
        LEVEL_DONE = 4'd5,
        PAUSED     = 4'd6,
        WIN        = 4'd7,
        LOSE       = 4'd8
    } game_state_e;

    localparam logic [2:0] MSG_START = 3'd0;
    localparam logic [2:0] MSG_WIN   = 3'd1;
    localparam logic [2:0] MSG_LOSE  = 3'd2;
    localparam logic [2:0] MSG_LEVEL = 3'd3;
    localparam logic [2:0] MSG_PAUSE = 3'd4;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level goes high.
module rise_detect (
    input  logic clk,
    input  logic resetN,
    input  logic in,
    output logic pulse
);

    logic prev_q;

    // Remember last cycle's level so a held input yields a single pulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) prev_q <= 1'b0;
        else         prev_q <= in;
    end

    assign pulse = in & ~prev_q;

endmodule

// File: rtl/level_game_control.sv
// Game-flow sequencer: tracks lives and level and decodes the start/message
// controls from the current state.
// Optional pause feature: define PAUSE_GAME_EN to let a space edge in PLAY
// freeze the game until the next space edge.
//
// state      | meaning
// PRE_GAME   | start screen, waiting for space
// PLAY       | character and bubbles live
// LOST_LIFE  | hit taken, waiting for timer (or game over at 0 lives)
// RESPAWN    | waiting for timer before resuming play
// GAIN_LIFE  | bonus picked up, life credited on timer
// LEVEL_DONE | level-up message, level advanced on timer
// PAUSED     | game frozen, pause message shown
// WIN        | last level cleared, waiting for space
// LOSE       | out of lives, waiting for space
module level_game_control
    import game_pkg::*;
#(
    parameter  int LIVES_W    = 4,
    parameter  int INIT_LIVES = 3,
    parameter  int MAX_LIVES  = 9,
    parameter  int NUM_LEVELS = 4,
    localparam int LEVEL_W    = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               charHit,
    input  logic               counter,
    input  logic               level_clear,
    input  logic               space_press,
    input  logic               gotLife,
    output logic               bubbleStart,
    output logic               charStart,
    output logic [LIVES_W-1:0] lives,
    output logic [LEVEL_W-1:0] level,
    output logic               displayMessage,
    output logic [2:0]         message,
    output logic               gameover
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_MAX  = LIVES_W'(MAX_LIVES);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

    game_state_e        state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               space_edge;

    rise_detect u_space_edge (
        .clk    (clk),
        .resetN (resetN),
        .in     (space_press),
        .pulse  (space_edge)
    );

    // State, lives and level registers; reset discards all game progress.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= PRE_GAME;
            lives_q <= LIVES_INIT;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            level_q <= level_d;
        end
    end

    // Next-state logic; lives/level only move on the transitions that own them.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        case (state_q)
            PRE_GAME: begin
                if (space_edge) state_d = PLAY;
            end
            PLAY: begin
                if (charHit) begin
                    state_d = LOST_LIFE;
                    if (lives_q != '0) lives_d = lives_q - 1'b1;
                end else if (level_clear) begin
                    state_d = (level_q == LAST_LEVEL) ? WIN : LEVEL_DONE;
                end else if (gotLife) begin
                    state_d = GAIN_LIFE;
                end
`ifdef PAUSE_GAME_EN
                else if (space_edge) begin
                    state_d = PAUSED;
                end
`endif
            end
            LOST_LIFE: begin
                // Game over takes precedence over the respawn timer.
                if (lives_q == '0)  state_d = LOSE;
                else if (counter)   state_d = RESPAWN;
            end
            RESPAWN: begin
                if (counter) state_d = PLAY;
            end
            GAIN_LIFE: begin
                if (counter) begin
                    state_d = PLAY;
                    if (lives_q < LIVES_MAX) lives_d = lives_q + 1'b1;
                end
            end
            LEVEL_DONE: begin
                if (counter) begin
                    state_d = PLAY;
                    if (level_q < LAST_LEVEL) level_d = level_q + 1'b1;
                end
            end
`ifdef PAUSE_GAME_EN
            PAUSED: begin
                if (space_edge) state_d = PLAY;
            end
`endif
            WIN, LOSE: begin
                if (space_edge) begin
                    state_d = PRE_GAME;
                    lives_d = LIVES_INIT;
                    level_d = '0;
                end
            end
            default: state_d = PRE_GAME;
        endcase
    end

    // Moore decode of the display and movement controls.
    always_comb begin
        bubbleStart    = 1'b0;
        charStart      = 1'b0;
        displayMessage = 1'b0;
        message        = MSG_START;
        gameover       = 1'b0;
        case (state_q)
            PRE_GAME: begin
                bubbleStart    = 1'b1;
                displayMessage = 1'b1;
                message        = MSG_START;
            end
            PLAY, GAIN_LIFE: begin
                charStart = 1'b1;
            end
            LEVEL_DONE: begin
                bubbleStart    = 1'b1;
                displayMessage = 1'b1;
                message        = MSG_LEVEL;
            end
            PAUSED: begin
                displayMessage = 1'b1;
                message        = MSG_PAUSE;
            end
            WIN: begin
                displayMessage = 1'b1;
                message        = MSG_WIN;
            end
            LOSE: begin
                displayMessage = 1'b1;
                message        = MSG_LOSE;
                gameover       = 1'b1;
            end
            default: ;
        endcase
    end

    assign lives = lives_q;
    assign level = level_q;

endmodule

// File: tb/tb_level_game_control.sv
// Bench for level_game_control: directed game scenarios followed by random
// play, with a game-rule reference model feeding an expectation queue that a
// separate monitor drains one entry per clock.
module tb_level_game_control;

    localparam int LIVES_W = 4;
    localparam int INIT    = 3;
    localparam int MAXL    = 9;
    localparam int NLEV    = 4;
    localparam int LEVEL_W = 2;

    // Output "look" = {bubbleStart, charStart, displayMessage, message, gameover}
    localparam logic [6:0] L_PRE   = 7'b1_0_1_000_0;
    localparam logic [6:0] L_PLAY  = 7'b0_1_0_000_0;
    localparam logic [6:0] L_IDLE  = 7'b0_0_0_000_0;
    localparam logic [6:0] L_LVL   = 7'b1_0_1_011_0;
    localparam logic [6:0] L_WIN   = 7'b0_0_1_001_0;
    localparam logic [6:0] L_LOSE  = 7'b0_0_1_010_1;
    localparam logic [6:0] L_PAUSE = 7'b0_0_1_100_0;

    // Model game phases (independent of the RTL encoding).
    localparam int M_PRE = 10, M_PLAY = 11, M_HIT = 12, M_RESP = 13, M_BONUS = 14,
                   M_LVL = 15, M_PAUSE = 16, M_WIN = 17, M_LOSE = 18;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic charHit = 1'b0, counter = 1'b0, level_clear = 1'b0;
    logic space_press = 1'b0, gotLife = 1'b0;
    logic bubbleStart, charStart, displayMessage, gameover;
    logic [LIVES_W-1:0] lives;
    logic [LEVEL_W-1:0] level;
    logic [2:0] message;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [6:0] look;
        int         lives;
        int         level;
        string      tag;
    } exp_t;

    exp_t expq[$];

    int m_mode  = M_PRE;
    int m_lives = INIT;
    int m_level = 0;
    bit m_prev  = 1'b0;

    level_game_control #(
        .LIVES_W    (LIVES_W),
        .INIT_LIVES (INIT),
        .MAX_LIVES  (MAXL),
        .NUM_LEVELS (NLEV)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .charHit        (charHit),
        .counter        (counter),
        .level_clear    (level_clear),
        .space_press    (space_press),
        .gotLife        (gotLife),
        .bubbleStart    (bubbleStart),
        .charStart      (charStart),
        .lives          (lives),
        .level          (level),
        .displayMessage (displayMessage),
        .message        (message),
        .gameover       (gameover)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] look_of(input int mode);
        case (mode)
            M_PRE:           return L_PRE;
            M_PLAY, M_BONUS: return L_PLAY;
            M_LVL:           return L_LVL;
            M_PAUSE:         return L_PAUSE;
            M_WIN:           return L_WIN;
            M_LOSE:          return L_LOSE;
            default:         return L_IDLE;
        endcase
    endfunction

    function automatic exp_t model_view(input string tag);
        exp_t e;
        e.look  = look_of(m_mode);
        e.lives = m_lives;
        e.level = m_level;
        e.tag   = tag;
        return e;
    endfunction

    // Game rules applied for one clock given this cycle's inputs.
    task automatic model_step(input bit ch, input bit cnt, input bit lc,
                              input bit sp, input bit gl);
        bit edge_seen;
        edge_seen = sp && !m_prev;
        m_prev = sp;
        case (m_mode)
            M_PRE:  if (edge_seen) m_mode = M_PLAY;
            M_PLAY: begin
                if (ch) begin
                    m_mode = M_HIT;
                    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                end else if (lc) begin
                    m_mode = (m_level == NLEV - 1) ? M_WIN : M_LVL;
                end else if (gl) begin
                    m_mode = M_BONUS;
                end
`ifdef PAUSE_GAME_EN
                else if (edge_seen) m_mode = M_PAUSE;
`endif
            end
            M_HIT: begin
                if (m_lives == 0) m_mode = M_LOSE;
                else if (cnt)     m_mode = M_RESP;
            end
            M_RESP:  if (cnt) m_mode = M_PLAY;
            M_BONUS: if (cnt) begin
                m_mode = M_PLAY;
                if (m_lives < MAXL) m_lives++;
            end
            M_LVL: if (cnt) begin
                m_mode = M_PLAY;
                if (m_level < NLEV - 1) m_level++;
            end
            M_PAUSE: if (edge_seen) m_mode = M_PLAY;
            M_WIN, M_LOSE: if (edge_seen) begin
                m_mode = M_PRE;
                m_lives = INIT;
                m_level = 0;
            end
            default: m_mode = M_PRE;
        endcase
    endtask

    task automatic compare(input exp_t e);
        logic [6:0] got;
        got = {bubbleStart, charStart, displayMessage, message, gameover};
        checks++;
        if (got !== e.look || int'(lives) != e.lives || int'(level) != e.level) begin
            failures++;
            $display("FAIL %s look got %b exp %b lives got %0d exp %0d level got %0d exp %0d (t=%0t)",
                     e.tag, got, e.look, lives, e.lives, level, e.level, $time);
        end
    endtask

    // Monitor: one expectation per clock, sampled just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                compare(e);
            end
        end
    end

    task automatic step(input bit ch, input bit cnt, input bit lc,
                        input bit sp, input bit gl, input string tag);
        @(negedge clk);
        resetN      = 1'b1;
        charHit     = ch;
        counter     = cnt;
        level_clear = lc;
        space_press = sp;
        gotLife     = gl;
        model_step(ch, cnt, lc, sp, gl);
        expq.push_back(model_view(tag));
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        resetN      = 1'b0;
        charHit     = 1'b0;
        counter     = 1'b0;
        level_clear = 1'b0;
        space_press = 1'b0;
        gotLife     = 1'b0;
        m_mode  = M_PRE;
        m_lives = INIT;
        m_level = 0;
        m_prev  = 1'b0;
        expq.push_back(model_view("reset_held"));
        #1;
        e.look = L_PRE; e.lives = INIT; e.level = 0; e.tag = "reset_async";
        compare(e);
    endtask

    // Fixed-expectation check of the cycle just stepped.
    task automatic chk(input string tag, input logic [6:0] look,
                       input int lv, input int lev);
        exp_t e;
        @(posedge clk);
        #2;
        e.look = look; e.lives = lv; e.level = lev; e.tag = tag;
        compare(e);
    endtask

    initial begin
        bit rch, rcnt, rlc, rsp, rgl;

        do_reset();

        // Held space key: exactly one transition out of PRE_GAME.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, "space_held");
        step(0, 0, 0, 0, 0, "space_release");
        chk("held_space_one_edge", L_PLAY, 3, 0);

        // Three hits down to game over.
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0, 0, "hit");
            chk("hit_lives", L_IDLE, 2 - k, 0);
            if (k < 2) begin
                step(0, 1, 0, 0, 0, "to_respawn");
                chk("respawn", L_IDLE, 2 - k, 0);
                step(0, 1, 0, 0, 0, "to_play");
            end
        end
        step(0, 0, 0, 0, 0, "to_lose");
        chk("lose_state", L_LOSE, 0, 0);
        step(0, 0, 0, 1, 0, "lose_restart");
        chk("restart_pre", L_PRE, 3, 0);
        step(0, 0, 0, 0, 0, "idle");
        step(0, 0, 0, 1, 0, "start");
        chk("start_play", L_PLAY, 3, 0);

        // Lives up to the ceiling, then one more bonus saturates.
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 0, 0, 1, "bonus");
            step(0, 1, 0, 0, 0, "bonus_tick");
        end
        chk("lives_at_max", L_PLAY, 9, 0);
        step(0, 0, 0, 0, 1, "bonus_at_max");
        chk("gain_state", L_PLAY, 9, 0);
        step(0, 1, 0, 0, 0, "bonus_at_max_tick");
        chk("lives_saturate", L_PLAY, 9, 0);

        // Hit beats level_clear in the same cycle.
        step(1, 0, 1, 0, 0, "hit_and_clear");
        chk("hit_priority", L_IDLE, 8, 0);
        step(0, 1, 0, 0, 0, "to_respawn");
        step(0, 1, 0, 0, 0, "to_play");

        // Walk through all levels to WIN.
        for (int lv = 0; lv < 3; lv++) begin
            step(0, 0, 1, 0, 0, "clear");
            chk("level_done", L_LVL, 8, lv);
            step(0, 1, 0, 0, 0, "level_tick");
            chk("level_up", L_PLAY, 8, lv + 1);
        end
        step(0, 0, 1, 0, 0, "clear_last");
        chk("win_state", L_WIN, 8, 3);
        step(0, 0, 0, 1, 0, "win_restart");
        chk("win_restart", L_PRE, 3, 0);
        step(0, 0, 0, 0, 0, "idle");
        step(0, 0, 0, 1, 0, "start");
        step(0, 0, 0, 0, 0, "release");

        // Space edge during play: pause when enabled, ignored otherwise.
        step(0, 0, 0, 1, 0, "space_in_play");
`ifdef PAUSE_GAME_EN
        chk("pause_enter", L_PAUSE, 3, 0);
        step(1, 1, 1, 0, 1, "paused_inputs");
        chk("pause_ignore", L_PAUSE, 3, 0);
        step(0, 0, 0, 1, 0, "pause_exit");
        chk("pause_exit", L_PLAY, 3, 0);
`else
        chk("space_ignored", L_PLAY, 3, 0);
`endif

        // Reset in LEVEL_DONE abandons progress.
        step(0, 0, 0, 0, 0, "release");
        step(0, 0, 1, 0, 0, "clear");
        step(0, 1, 0, 0, 0, "level_tick");
        step(0, 0, 1, 0, 0, "clear");
        chk("level_done_pre_reset", L_LVL, 3, 1);
        do_reset();
        step(0, 0, 0, 0, 0, "after_reset");
        chk("reset_mid_game", L_PRE, 3, 0);

        // Random play against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                rch  = ($urandom_range(0, 11) == 0);
                rcnt = ($urandom_range(0, 2) == 0);
                rlc  = ($urandom_range(0, 14) == 0);
                rsp  = ($urandom_range(0, 3) == 0);
                rgl  = ($urandom_range(0, 7) == 0);
                step(rch, rcnt, rlc, rsp, rgl, "random");
            end
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL queue_drain pending got %0d exp 0", expq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
